// File: rtl/is_uart_rx_ctrl.sv
// rtl/is_uart_rx_ctrl.sv - UART receive sequencer: start detect, bit walk, word delivery
//
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   uart_ce_i       oversample tick, used only while idle to look for the start edge
//   rx_ce_i         mid-bit strobe from the sample counter
//   rxd_i           raw serial line (asynchronous)
//   rxct_r_o        sample counter restart, high while idle
//   rx_data_o       received word, with frame_err_o / parity_err_o status
//   rx_valid_o      word available; cleared by rx_ready_i handshake
//   rx_ready_i      consumer accepts word
//   overrun_o       one-cycle pulse when a completed frame had to be dropped
//   busy_o          frame in progress

module is_uart_rx_ctrl #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              uart_ce_i,
    input  logic              rx_ce_i,
    input  logic              rxd_i,
    output logic              rxct_r_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state;
    logic              rxd_m;
    logic              rxd_s;
    logic [DATA_W-1:0] shreg;
    logic [3:0]        bit_cnt;
    logic              ferr;
    logic              perr;

    localparam logic PAR_ODD = (PARITY_ODD != 0);

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd_i;
            rxd_s <= rxd_m;
        end
    end

    assign rxct_r_o = (state == S_IDLE);
    assign busy_o   = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= S_IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            ferr         <= 1'b0;
            perr         <= 1'b0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            // Handshake clear; a DONE reload below overrides it in the same cycle.
            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (uart_ce_i && !rxd_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_ce_i) begin
                        if (!rxd_s) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                            ferr    <= 1'b0;
                            perr    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_ce_i) begin
                        // LSB arrives first; shifting in at the top leaves it at bit 0.
                        shreg <= {rxd_s, shreg[DATA_W-1:1]};
                        if (bit_cnt == 4'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (rx_ce_i) begin
                        perr  <= (^shreg) ^ rxd_s ^ PAR_ODD;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (rx_ce_i) begin
                        ferr <= ferr | !rxd_s;
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            state <= S_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!rx_valid_o || rx_ready_i) begin
                        rx_data_o    <= shreg;
                        frame_err_o  <= ferr;
                        parity_err_o <= perr;
                        rx_valid_o   <= 1'b1;
                    end else begin
                        overrun_o <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/is_uart_rx_ctrl.md
Name: is_uart_rx_ctrl

Overview:
Receive-side sequencer for the UART controller. It detects the start bit and drives the sample counter's restart (rxct_r_o). It consumes the counter's mid-bit strobe (rx_ce_i) to walk start/data/parity/stop, then presents the assembled word on a valid/ready interface with frame, parity and overrun status. It sits between the RX pin synchronizer domain and the controller's RX FIFO/register interface, paired with the sample counter (RATIO = 8 from is_pkg_uart_controller).

Parameters:
DATA_W, 8, data bits per frame (5..9), LSB first
PARITY_EN, 0, 1 = parity bit follows data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits checked (1 or 2)

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous, active-low reset
uart_ce_i  in  1  oversample tick (RATIO per bit period)
rx_ce_i  in  1  mid-bit strobe from sample counter
rxd_i  in  1  raw serial input, asynchronous
rxct_r_o  out  1  sample counter restart, high while idle
rx_data_o  out  DATA_W  received word
rx_valid_o  out  1  word available
rx_ready_i  in  1  consumer accepts word
frame_err_o  out  1  stop bit was 0 for the word on rx_data_o
parity_err_o  out  1  parity mismatch for the word on rx_data_o
overrun_o  out  1  one-cycle pulse: completed frame dropped
busy_o  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset: state IDLE, sync flops = 1, rx_data_o = 0, rx_valid_o/frame_err_o/parity_err_o/overrun_o = 0, busy_o = 0, rxct_r_o = 1.
- rxd_i passes a 2-flop synchronizer (rxd_s). All FSM decisions use rxd_s.
- rxct_r_o = (state == IDLE), combinational from state.
- IDLE: on uart_ce_i && rxd_s==0 -> START. The counter leaves reset and its first rx_ce_i arrives on the 4th uart_ce_i after entry, then every 8th.
- START: on rx_ce_i: rxd_s==0 -> DATA, bit_cnt=0; rxd_s==1 -> IDLE (glitch rejected, nothing reported).
- DATA: on rx_ce_i, shift rxd_s in at MSB of shift reg (LSB-first line order) and bit_cnt++. After the DATA_W-th bit: -> PARITY if PARITY_EN, else STOP.
- PARITY: on rx_ce_i, capture the parity bit; perr = (XOR(data) ^ bit ^ PARITY_ODD) != 0. -> STOP.
- STOP: on rx_ce_i, ferr |= (rxd_s==0). When STOP_BITS bits are sampled -> DONE. With 2 stop bits, the second is still sampled after a failed first.
- DONE (1 cycle): deliver, then -> IDLE.
  - If !rx_valid_o, or (rx_valid_o && rx_ready_i) this cycle: load rx_data_o/frame_err_o/parity_err_o and set rx_valid_o=1.
  - Otherwise: keep the old word and flags, pulse overrun_o for 1 cycle.
- Handshake: rx_valid_o holds with stable data/flags until it is high in the same cycle as rx_ready_i, then clears next cycle unless DONE reloads it. rx_ready_i while !rx_valid_o has no effect.
- rx_ce_i outside START/DATA/PARITY/STOP is ignored. uart_ce_i is used only in IDLE.
- A frame with errors is still delivered (flags set), not dropped.
- Back-to-back frames: a start edge is accepted on the first uart_ce_i in IDLE after DONE.
- rstn_i low mid-frame: immediate return to reset values. A partial word is never delivered.

Test Plan:
1. uart_ce_i every clk, 8N1, frame 0xA5 with 8 ticks/bit, ready=1 -> rx_data_o=0xA5, rx_valid_o for 1 cycle, both error flags 0, rxct_r_o low from start detect until DONE.
2. rxd_i low for 2 uart_ce ticks, then high -> FSM returns to IDLE at the first rx_ce_i, no rx_valid_o, rxct_r_o back to 1.
3. Frame 0x3C with stop bit driven 0 -> rx_data_o=0x3C, frame_err_o=1, rx_valid_o=1.
4. PARITY_EN=1, PARITY_ODD=0: frame 0x3C with parity bit 1 -> parity_err_o=1. The same frame with parity bit 0 -> parity_err_o=0.
5. ready=0, frames 0x11 then 0x22 -> rx_data_o stays 0x11 and overrun_o pulses once at the end of the second frame. Then raise ready in the DONE cycle of a third frame 0x33 -> 0x33 loaded, no overrun.
6. Assert rstn_i low during data bit 4 of a frame -> all outputs at reset values, busy_o=0. A following clean frame 0x5A is received correctly.
